// File: rtl/pulse_meter.sv
// pulse_meter: measures the period, high width or low width of an asynchronous
// pulse in clk cycles, with a saturating counter and an overflow flag.
module pulse_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NPER_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [1:0]        mode,
    input  logic [NPER_W-1:0] nper,
    input  logic              clr,
    output logic [CNT_W-1:0]  meas,
    output logic              meas_valid,
    output logic              ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_MEAS  = 2'd2;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_MULTI = 2'd1;
    localparam logic [1:0] MODE_HIGH  = 2'd2;
    localparam logic [1:0] MODE_LOW   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [1:0]             mode_q;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NPER_W-1:0] per_q, per_d;
    logic [NPER_W-1:0] nper_q, nper_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic              sync_c;
    logic              rise_c;
    logic              fall_c;
    logic              start_c;
    logic              end_c;
    logic              abort_c;
    logic [NPER_W-1:0] target_c;
    logic [NPER_W-1:0] per_inc_c;
    logic [CNT_W-1:0]  inc_c;
    logic              inc_sat_c;

    // Synchronizer chain, edge-history flop and previous mode for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            mode_q <= MODE_OFF;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            hist_q <= sync_q[SYNC_STAGES-1];
            mode_q <= mode;
        end
    end

    // Edge detection, edge selection per mode and saturating increment
    always_comb begin
        sync_c    = sync_q[SYNC_STAGES-1];
        rise_c    = sync_c & ~hist_q;
        fall_c    = ~sync_c & hist_q;
        start_c   = (mode == MODE_LOW) ? fall_c : rise_c;
        end_c     = (mode == MODE_HIGH) ? fall_c : rise_c;
        abort_c   = clr | (mode != mode_q);
        target_c  = (nper_q == '0) ? NPER_W'(1) : nper_q;
        per_inc_c = per_q + NPER_W'(1);
        inc_c     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        inc_sat_c = sat_q | (cnt_q == CNT_MAX);
    end

    // Measurement FSM next state and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        nper_d  = nper_q;
        sat_d   = sat_q;
        meas_d  = meas_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;

        if (abort_c) begin
            // clr or a mode change discards the partial measurement
            state_d = ST_IDLE;
            cnt_d   = '0;
            per_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode != MODE_OFF) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (mode == MODE_OFF) begin
                        state_d = ST_IDLE;
                    end else if (start_c) begin
                        cnt_d   = '0;
                        per_d   = '0;
                        sat_d   = 1'b0;
                        nper_d  = nper;
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (!end_c) begin
                        cnt_d = inc_c;
                        sat_d = inc_sat_c;
                    end else if (mode == MODE_MULTI) begin
                        if (per_inc_c == target_c) begin
                            // Final period: report, then restart on this same edge
                            meas_d  = inc_c;
                            valid_d = 1'b1;
                            ovf_d   = inc_sat_c;
                            cnt_d   = '0;
                            per_d   = '0;
                            sat_d   = 1'b0;
                            nper_d  = nper;
                        end else begin
                            per_d = per_inc_c;
                            cnt_d = inc_c;
                            sat_d = inc_sat_c;
                        end
                    end else begin
                        meas_d  = inc_c;
                        valid_d = 1'b1;
                        ovf_d   = inc_sat_c;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            nper_q  <= '0;
            sat_q   <= 1'b0;
            meas_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            nper_q  <= nper_d;
            sat_q   <= sat_d;
            meas_q  <= meas_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign meas       = meas_q;
    assign meas_valid = valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: drives directed and random pulse trains into two pulse_meter
// instances (16-bit/2-stage and 8-bit/3-stage) and checks every strobe against
// a model computed from the recorded pulse_in edge times.
module tb_pulse_meter;

    localparam int CW_A = 16;
    localparam int S_A  = 2;
    localparam int CW_B = 8;
    localparam int S_B  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_in;
    logic [1:0]  mode;
    logic [3:0]  nper;
    logic        clr;
    logic [15:0] meas_a;
    logic        mv_a;
    logic        ovf_a;
    logic [7:0]  meas_b;
    logic        mv_b;
    logic        ovf_b;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    // pulse_in edge log: drive cycle, new level, nper at that moment
    int  ev_t[$];
    bit  ev_l[$];
    int  ev_n[$];
    // observed strobes per instance
    int     oa_t[$];
    longint oa_m[$];
    bit     oa_o[$];
    int     ob_t[$];
    longint ob_m[$];
    bit     ob_o[$];
    // expected strobes from the model
    int     xt[$];
    longint xm[$];
    bit     xo[$];

    pulse_meter #(.CNT_W(CW_A), .NPER_W(4), .SYNC_STAGES(S_A)) u_dut_a (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .mode(mode), .nper(nper), .clr(clr),
        .meas(meas_a), .meas_valid(mv_a), .ovf(ovf_a)
    );

    pulse_meter #(.CNT_W(CW_B), .NPER_W(4), .SYNC_STAGES(S_B)) u_dut_b (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .mode(mode), .nper(nper), .clr(clr),
        .meas(meas_b), .meas_valid(mv_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mv_a) begin
            oa_t.push_back(cyc);
            oa_m.push_back(longint'(meas_a));
            oa_o.push_back(ovf_a);
        end
        if (mv_b) begin
            ob_t.push_back(cyc);
            ob_m.push_back(longint'(meas_b));
            ob_o.push_back(ovf_b);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        ev_t.delete(); ev_l.delete(); ev_n.delete();
        oa_t.delete(); oa_m.delete(); oa_o.delete();
        ob_t.delete(); ob_m.delete(); ob_o.delete();
    endtask

    task automatic drive(input logic v);
        pulse_in = v;
        ev_t.push_back(cyc);
        ev_l.push_back(v);
        ev_n.push_back(int'(nper));
    endtask

    task automatic period_n(input int hi, input int lo, input int nn);
        drive(1'b1);
        tick(hi);
        drive(1'b0);
        tick(lo / 2);
        nper = 4'(nn);
        tick(lo - lo / 2);
    endtask

    task automatic period(input int hi, input int lo);
        period_n(hi, lo, int'(nper));
    endtask

    task automatic push_exp(input int t_end, input longint x, input int s, input longint maxv);
        xt.push_back(t_end + s + 1);
        xm.push_back((x > maxv) ? maxv : x);
        xo.push_back(x > maxv);
    endtask

    // Expected strobes from the edge log: spans between the selected edges
    task automatic model(input int m, input int s, input int cw);
        int     r[$];
        int     rn[$];
        int     j;
        int     k;
        longint maxv;
        maxv = (longint'(1) << cw) - 1;
        xt.delete(); xm.delete(); xo.delete();
        foreach (ev_t[i]) begin
            if (ev_l[i]) begin
                r.push_back(ev_t[i]);
                rn.push_back(ev_n[i]);
            end
        end
        if (m == 1) begin
            j = 0;
            while (j < r.size()) begin
                k = (rn[j] == 0) ? 1 : rn[j];
                if (j + k >= r.size()) break;
                push_exp(r[j + k], longint'(r[j + k] - r[j]), s, maxv);
                j = j + k;
            end
        end else begin
            for (int i = 0; i + 1 < ev_t.size(); i++) begin
                if ((m == 2 && ev_l[i] && !ev_l[i + 1]) || (m == 3 && !ev_l[i] && ev_l[i + 1]))
                    push_exp(ev_t[i + 1], longint'(ev_t[i + 1] - ev_t[i]), s, maxv);
            end
        end
    endtask

    task automatic compare(input string tag, input int which);
        int     ot[$];
        longint om[$];
        bit     oo[$];
        if (which == 0) begin
            ot = oa_t; om = oa_m; oo = oa_o;
        end else begin
            ot = ob_t; om = ob_m; oo = ob_o;
        end
        chk({tag, " strobe count"}, longint'(ot.size()), longint'(xt.size()));
        for (int i = 0; i < xt.size() && i < ot.size(); i++) begin
            chk($sformatf("%s[%0d] strobe cycle", tag, i), longint'(ot[i]), longint'(xt[i]));
            chk($sformatf("%s[%0d] meas", tag, i), om[i], xm[i]);
            chk($sformatf("%s[%0d] ovf", tag, i), longint'(oo[i]), longint'(xo[i]));
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [3:0] n);
        mode = 2'd0;
        pulse_in = 1'b0;
        tick(8);
        mode = m;
        nper = n;
        tick(4);
        clear_all();
    endtask

    task automatic finish_run(input string tag, input int m);
        tick(8);
        model(m, S_A, CW_A);
        compare({tag, "/a"}, 0);
        model(m, S_B, CW_B);
        compare({tag, "/b"}, 1);
    endtask

    initial begin
        int          m;
        int          n;
        int          hi;
        int          lo;
        int          nn;
        logic [15:0] saved_a;
        logic [7:0]  saved_b;

        rst = 1'b1; pulse_in = 1'b0; mode = 2'd0; nper = 4'd0; clr = 1'b0;
        tick(3);
        chk("reset meas_a", longint'(meas_a), 0);
        chk("reset valid_a", longint'(mv_a), 0);
        chk("reset ovf_a", longint'(ovf_a), 0);
        chk("reset meas_b", longint'(meas_b), 0);
        rst = 1'b0;
        tick(2);

        // Multi-period, nper = 1, 10/10: 20 per strobe, first on the second rise
        start_run(2'd1, 4'd1);
        for (int p = 0; p < 5; p++) period(10, 10);
        finish_run("m1n1", 1);

        // nper = 4 accumulates 80 with no lost period
        start_run(2'd1, 4'd4);
        for (int p = 0; p < 9; p++) period(10, 10);
        finish_run("m1n4", 1);

        // nper = 0 behaves as 1
        start_run(2'd1, 4'd0);
        for (int p = 0; p < 4; p++) period(10, 10);
        finish_run("m1n0", 1);

        // High width and low width, 7/13
        start_run(2'd2, 4'd0);
        for (int p = 0; p < 4; p++) period(7, 13);
        finish_run("m2", 2);
        start_run(2'd3, 4'd0);
        for (int p = 0; p < 4; p++) period(7, 13);
        finish_run("m3", 3);

        // Saturation on the 8-bit instance, then a clean 50-cycle pulse
        start_run(2'd2, 4'd0);
        period(300, 20);
        period(50, 20);
        finish_run("sat", 2);

        // clr mid-pulse: no strobe, meas held, next pulse measured
        start_run(2'd2, 4'd0);
        period(9, 6);
        finish_run("clr_pre", 2);
        clear_all();
        saved_a = meas_a;
        saved_b = meas_b;
        pulse_in = 1'b1;
        tick(6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(4);
        pulse_in = 1'b0;
        tick(10);
        chk("clr no strobe a", longint'(oa_t.size()), 0);
        chk("clr no strobe b", longint'(ob_t.size()), 0);
        chk("clr meas held a", longint'(meas_a), longint'(saved_a));
        chk("clr meas held b", longint'(meas_b), longint'(saved_b));
        clear_all();
        period(11, 5);
        period(11, 5);
        finish_run("clr_post", 2);

        // Mode switch 1 -> 2 mid-high: partial period dropped
        start_run(2'd1, 4'd1);
        period(10, 10);
        period(10, 10);
        drive(1'b1);
        tick(6);
        mode = 2'd2;
        tick(1);
        finish_run("sw_pre", 1);
        clear_all();
        saved_a = meas_a;
        pulse_in = 1'b0;
        tick(8);
        chk("switch no strobe a", longint'(oa_t.size()), 0);
        chk("switch meas held a", longint'(meas_a), longint'(saved_a));
        clear_all();
        period(8, 7);
        period(8, 7);
        finish_run("sw_post", 2);

        // Asynchronous reset mid-measurement
        start_run(2'd2, 4'd0);
        period(12, 5);
        finish_run("rst_pre", 2);
        pulse_in = 1'b1;
        tick(6);
        #3 rst = 1'b1;
        #1;
        chk("async rst meas_a", longint'(meas_a), 0);
        chk("async rst valid_a", longint'(mv_a), 0);
        chk("async rst ovf_a", longint'(ovf_a), 0);
        chk("async rst meas_b", longint'(meas_b), 0);
        chk("async rst valid_b", longint'(mv_b), 0);
        chk("async rst ovf_b", longint'(ovf_b), 0);
        pulse_in = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
        clear_all();
        period(15, 6);
        period(15, 6);
        finish_run("rst_post", 2);

        // Random modes, widths and mid-accumulation nper changes
        for (int r = 0; r < 8; r++) begin
            m = int'($urandom_range(1, 3));
            n = int'($urandom_range(0, 5));
            start_run(2'(m), 4'(n));
            for (int p = 0; p < 7; p++) begin
                hi = int'($urandom_range(3, 40));
                lo = int'($urandom_range(4, 40));
                nn = int'(nper);
                if (m == 1 && $urandom_range(0, 3) == 0) nn = int'($urandom_range(0, 5));
                period_n(hi, lo, nn);
            end
            finish_run($sformatf("rand%0d_m%0d", r, m), m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
